// File: rtl/complex_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : complex_pkg
//  Brief    : Shared types and helpers for the packed complex datapath
//             (real in the upper half, imag in the lower half).
//  Revision : 1.0
// ============================================================================
package complex_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Opcodes of the companion ALU, kept here for an opcode-mapped wrapper
    localparam logic [1:0] c_op_add = 2'd0;
    localparam logic [1:0] c_op_sub = 2'd1;
    localparam logic [1:0] c_op_mul = 2'd2;
    localparam logic [1:0] c_op_div = 2'd3;

    function automatic logic [2*WIDTH-1:0] cpack(input logic [WIDTH-1:0] re,
                                                 input logic [WIDTH-1:0] im);
        return {re, im};
    endfunction

    function automatic logic [WIDTH-1:0] cre(input logic [2*WIDTH-1:0] z);
        return z[2*WIDTH-1:WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] cim(input logic [2*WIDTH-1:0] z);
        return z[WIDTH-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/complex_divider_if.sv
`default_nettype none
// ============================================================================
//  Module   : complex_divider_if
//  Brief    : Start/busy/done handshake and operand/result bus of the
//             complex divider.
//  Revision : 1.0
// ============================================================================
interface complex_divider_if #(
    parameter int WIDTH = complex_pkg::WIDTH
);
    logic                 start;
    logic [2*WIDTH-1:0]   operand1;
    logic [2*WIDTH-1:0]   operand2;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic                 div_by_zero;
    logic                 overflow;

    modport master (
        output start, operand1, operand2,
        input  busy, done, result, div_by_zero, overflow
    );

    modport slave (
        input  start, operand1, operand2,
        output busy, done, result, div_by_zero, overflow
    );
endinterface
`default_nettype wire

// File: rtl/complex_divider_seq_udiv.sv
`default_nettype none
// ============================================================================
//  Module   : seq_udiv
//  Brief    : Unsigned restoring divider, one quotient bit per step, MSB first.
//  Revision : 1.0
// ============================================================================
module seq_udiv #(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [NBITS-1:0] dividend,
    input  logic [NBITS-1:0] divisor,
    output logic [NBITS-1:0] quotient,
    output logic [NBITS-1:0] remainder
);
    logic [NBITS-1:0] r_quo;
    logic [NBITS-1:0] r_rem;
    logic [NBITS-1:0] r_div;
    logic [NBITS:0]   w_shift;
    logic [NBITS:0]   w_diff;

    // The dividend shifts out of r_quo while quotient bits shift in behind it.
    // Since rem < divisor, the trial difference is below 2^NBITS unless it borrows.
    assign w_shift = {r_rem, r_quo[NBITS-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo <= '0;
            r_rem <= '0;
            r_div <= '0;
        end else if (load) begin
            r_quo <= dividend;
            r_rem <= '0;
            r_div <= divisor;
        end else if (step) begin
            if (!w_diff[NBITS]) begin
                r_rem <= w_diff[NBITS-1:0];
                r_quo <= {r_quo[NBITS-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[NBITS-1:0];
                r_quo <= {r_quo[NBITS-2:0], 1'b0};
            end
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/complex_divider.sv
`default_nettype none
// ============================================================================
//  Module   : complex_divider
//  Brief    : Sequential packed complex divider, (a+bi)/(c+di), one quotient
//             bit per cycle with truncation toward zero.
//  Revision : 1.0
// ============================================================================
module complex_divider
    import complex_pkg::*;
#(
    parameter int WIDTH = complex_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    complex_divider_if.slave   bus
);
    localparam int QBITS = 2 * WIDTH;
    localparam int NW    = 2 * WIDTH + 1;
    localparam int CW    = $clog2(QBITS);

    localparam logic [CW-1:0]    c_last    = CW'(QBITS - 1);
    localparam logic [QBITS-1:0] c_pos_lim = QBITS'((2 ** (WIDTH - 1)) - 1);
    localparam logic [QBITS-1:0] c_neg_lim = QBITS'(2 ** (WIDTH - 1));

    state_t               r_state;
    state_t               w_next;
    logic [2*WIDTH-1:0]   r_op1;
    logic [2*WIDTH-1:0]   r_op2;
    logic [CW-1:0]        r_cnt;
    logic                 r_sign_re;
    logic                 r_sign_im;
    logic                 r_dz;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_dz_out;
    logic                 r_ovf_out;

    logic                 w_load;
    logic                 w_step;
    logic                 w_busy;
    logic                 w_done;

    logic signed [WIDTH-1:0] w_a, w_b, w_c, w_d;
    logic signed [NW-1:0]    w_ax, w_bx, w_cx, w_dx;
    logic signed [NW-1:0]    w_nr, w_ni;
    logic signed [QBITS-1:0] w_cs, w_ds;
    logic [QBITS-1:0]        w_den;
    logic [QBITS-1:0]        w_nr_abs, w_ni_abs;

    logic [QBITS-1:0]     w_qre, w_qim;
    logic [QBITS-1:0]     w_rre, w_rim;
    logic                 w_ovf_re, w_ovf_im;
    logic [WIDTH-1:0]     w_res_re, w_res_im;
    logic [2*WIDTH-1:0]   w_fin_result;
    logic                 w_fin_ovf;
    logic                 w_unused;

    // ---------------- numerator / denominator formation ---------------------
    assign w_a = signed'(r_op1[2*WIDTH-1:WIDTH]);
    assign w_b = signed'(r_op1[WIDTH-1:0]);
    assign w_c = signed'(r_op2[2*WIDTH-1:WIDTH]);
    assign w_d = signed'(r_op2[WIDTH-1:0]);

    assign w_ax = NW'(w_a);
    assign w_bx = NW'(w_b);
    assign w_cx = NW'(w_c);
    assign w_dx = NW'(w_d);

    assign w_nr = w_ax * w_cx + w_bx * w_dx;
    assign w_ni = w_bx * w_cx - w_ax * w_dx;

    // c^2 + d^2 never exceeds 2^31, so the QBITS pattern is the unsigned value
    assign w_cs  = QBITS'(w_c);
    assign w_ds  = QBITS'(w_d);
    assign w_den = QBITS'(w_cs * w_cs + w_ds * w_ds);

    assign w_nr_abs = w_nr[NW-1] ? QBITS'(-w_nr) : QBITS'(w_nr);
    assign w_ni_abs = w_ni[NW-1] ? QBITS'(-w_ni) : QBITS'(w_ni);

    // ---------------- magnitude dividers ------------------------------------
    seq_udiv #(.NBITS(QBITS)) u_div_re (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load),
        .step      (w_step),
        .dividend  (w_nr_abs),
        .divisor   (w_den),
        .quotient  (w_qre),
        .remainder (w_rre)
    );

    seq_udiv #(.NBITS(QBITS)) u_div_im (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load),
        .step      (w_step),
        .dividend  (w_ni_abs),
        .divisor   (w_den),
        .quotient  (w_qim),
        .remainder (w_rim)
    );

    assign w_unused = ^{w_rre, w_rim};

    // ---------------- FSM ---------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) w_next = PREP;
            end
            PREP: begin
                w_busy = 1'b1;
                w_load = 1'b1;
                w_next = (w_den == '0) ? FIN : DIV;
            end
            DIV: begin
                w_busy = 1'b1;
                w_step = 1'b1;
                if (r_cnt == c_last) w_next = FIN;
            end
            FIN: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // ---------------- operand capture and per-operation state ---------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op1     <= '0;
            r_op2     <= '0;
            r_cnt     <= '0;
            r_sign_re <= 1'b0;
            r_sign_im <= 1'b0;
            r_dz      <= 1'b0;
        end else begin
            if (r_state == IDLE && bus.start) begin
                r_op1 <= bus.operand1;
                r_op2 <= bus.operand2;
            end
            if (r_state == PREP) begin
                r_cnt     <= '0;
                r_sign_re <= w_nr[NW-1];
                r_sign_im <= w_ni[NW-1];
                r_dz      <= (w_den == '0);
            end else if (r_state == DIV) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // ---------------- sign application and range check ----------------------
    assign w_ovf_re = r_sign_re ? (w_qre > c_neg_lim) : (w_qre > c_pos_lim);
    assign w_ovf_im = r_sign_im ? (w_qim > c_neg_lim) : (w_qim > c_pos_lim);
    assign w_res_re = r_sign_re ? (~w_qre[WIDTH-1:0] + WIDTH'(1)) : w_qre[WIDTH-1:0];
    assign w_res_im = r_sign_im ? (~w_qim[WIDTH-1:0] + WIDTH'(1)) : w_qim[WIDTH-1:0];

    assign w_fin_result = r_dz ? '0 : {w_res_re, w_res_im};
    assign w_fin_ovf    = !r_dz && (w_ovf_re || w_ovf_im);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result  <= '0;
            r_dz_out  <= 1'b0;
            r_ovf_out <= 1'b0;
        end else if (r_state == FIN) begin
            r_result  <= w_fin_result;
            r_dz_out  <= r_dz;
            r_ovf_out <= w_fin_ovf;
        end
    end

    // Outputs show the fresh values during the done cycle, held values otherwise
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.result      = (r_state == FIN) ? w_fin_result : r_result;
    assign bus.div_by_zero = (r_state == FIN) ? r_dz         : r_dz_out;
    assign bus.overflow    = (r_state == FIN) ? w_fin_ovf    : r_ovf_out;

endmodule
`default_nettype wire

// File: tb/tb_complex_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_complex_divider
//  Brief    : Directed self-checking bench for complex_divider.
//  Revision : 1.0
// ============================================================================
module tb_complex_divider;
    import complex_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    complex_divider_if #(.WIDTH(16)) dif ();

    complex_divider #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // Drive start for one cycle (cycle T); returns #1 after the edge opening T+1
    task automatic launch(input logic [31:0] o1, input logic [31:0] o2);
        @(posedge clk); #1;
        dif.start    = 1'b1;
        dif.operand1 = o1;
        dif.operand2 = o2;
        @(posedge clk); #1;
        dif.start    = 1'b0;
        dif.operand1 = $urandom;
        dif.operand2 = $urandom;
    endtask

    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (dif.done !== 1'b1 && lat < 80) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        dif.start    = 1'b1;
        dif.operand1 = 32'h000A_0014;
        dif.operand2 = 32'h0001_0002;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (dif.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", dif.busy); end
        n_cmp++; if (dif.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", dif.done); end
        n_cmp++; if (dif.result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h expected 0", dif.result); end
        n_cmp++; if (dif.div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dz: got %b expected 0", dif.div_by_zero); end
        n_cmp++; if (dif.overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", dif.overflow); end
        dif.start = 1'b0;
        rst_n     = 1'b1;
    endtask

    // (10+20i)/(1+2i) = 10, with cycle-exact busy/done checks
    task automatic test_plain();
        launch(32'h000A_0014, 32'h0001_0002);
        for (int k = 1; k <= 36; k++) begin
            n_cmp++;
            if (dif.busy !== (k <= 33)) begin
                n_err++; $display("FAIL plain_busy T+%0d: got %b expected %b", k, dif.busy, (k <= 33));
            end
            n_cmp++;
            if (dif.done !== (k == 34)) begin
                n_err++; $display("FAIL plain_done T+%0d: got %b expected %b", k, dif.done, (k == 34));
            end
            if (k == 34) begin
                n_cmp++; if (dif.result !== 32'h000A_0000) begin n_err++; $display("FAIL plain_result: got %h expected 000a0000", dif.result); end
                n_cmp++; if (dif.div_by_zero !== 1'b0) begin n_err++; $display("FAIL plain_dz: got %b expected 0", dif.div_by_zero); end
                n_cmp++; if (dif.overflow !== 1'b0) begin n_err++; $display("FAIL plain_ovf: got %b expected 0", dif.overflow); end
            end
            @(posedge clk); #1;
        end
    endtask

    logic [31:0] v_op1 [6] = '{32'hFFFB_000A, 32'h0007_0000, 32'hFFF9_0000,
                               32'h0001_0000, 32'h0007_0000, 32'h8000_0000};
    logic [31:0] v_op2 [6] = '{32'h0001_0002, 32'h0002_0000, 32'h0002_0000,
                               32'h0000_0001, 32'h0000_0002, 32'hFFFF_0000};
    logic [31:0] v_res [6] = '{32'h0003_0004, 32'h0003_0000, 32'hFFFD_0000,
                               32'h0000_FFFF, 32'h0000_FFFD, 32'h8000_0000};
    logic        v_ovf [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic test_vectors();
        int lat;
        for (int i = 0; i < 6; i++) begin
            launch(v_op1[i], v_op2[i]);
            wait_done(1, lat);
            n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL vec%0d_latency: got %0d expected 34", i, lat); end
            n_cmp++; if (dif.result !== v_res[i]) begin n_err++; $display("FAIL vec%0d_result: got %h expected %h", i, dif.result, v_res[i]); end
            n_cmp++; if (dif.overflow !== v_ovf[i]) begin n_err++; $display("FAIL vec%0d_ovf: got %b expected %b", i, dif.overflow, v_ovf[i]); end
            n_cmp++; if (dif.div_by_zero !== 1'b0) begin n_err++; $display("FAIL vec%0d_dz: got %b expected 0", i, dif.div_by_zero); end
            @(posedge clk); #1;
            n_cmp++; if (dif.done !== 1'b0) begin n_err++; $display("FAIL vec%0d_pulse: got %b expected 0", i, dif.done); end
            n_cmp++; if (dif.result !== v_res[i]) begin n_err++; $display("FAIL vec%0d_hold: got %h expected %h", i, dif.result, v_res[i]); end
        end
    endtask

    task automatic test_div_by_zero();
        int lat;
        launch(32'h1234_5678, 32'h0000_0000);
        wait_done(1, lat);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL dz_latency: got %0d expected 2", lat); end
        n_cmp++; if (dif.result !== 32'h0) begin n_err++; $display("FAIL dz_result: got %h expected 0", dif.result); end
        n_cmp++; if (dif.div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_flag: got %b expected 1", dif.div_by_zero); end
        n_cmp++; if (dif.overflow !== 1'b0) begin n_err++; $display("FAIL dz_ovf: got %b expected 0", dif.overflow); end
        launch(32'h000A_0014, 32'h0001_0002);
        repeat (9) @(posedge clk);
        #1;
        n_cmp++; if (dif.div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_hold: got %b expected 1", dif.div_by_zero); end
        wait_done(10, lat);
        n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL dz_next_latency: got %0d expected 34", lat); end
        n_cmp++; if (dif.div_by_zero !== 1'b0) begin n_err++; $display("FAIL dz_cleared: got %b expected 0", dif.div_by_zero); end
        n_cmp++; if (dif.result !== 32'h000A_0000) begin n_err++; $display("FAIL dz_next_result: got %h expected 000a0000", dif.result); end
    endtask

    task automatic test_start_while_busy();
        int lat;
        launch(32'hFFFB_000A, 32'h0001_0002);
        repeat (4) @(posedge clk);
        #1;
        dif.start = 1'b1; dif.operand1 = 32'h7FFF_7FFF; dif.operand2 = 32'h0001_0000;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        dif.start = 1'b1; dif.operand1 = 32'h0007_0000; dif.operand2 = 32'h0002_0000;
        @(posedge clk); #1;
        dif.start = 1'b0;
        n_cmp++; if (dif.busy !== 1'b1) begin n_err++; $display("FAIL busy_start_busy: got %b expected 1", dif.busy); end
        wait_done(21, lat);
        n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL busy_start_latency: got %0d expected 34", lat); end
        n_cmp++; if (dif.result !== 32'h0003_0004) begin n_err++; $display("FAIL busy_start_result: got %h expected 00030004", dif.result); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        launch(32'h000A_0014, 32'h0001_0002);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (dif.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", dif.busy); end
        n_cmp++; if (dif.done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b expected 0", dif.done); end
        n_cmp++; if (dif.result !== 32'h0) begin n_err++; $display("FAIL midrst_result: got %h expected 0", dif.result); end
        n_cmp++; if ({dif.div_by_zero, dif.overflow} !== 2'b00) begin n_err++; $display("FAIL midrst_flags: got %b expected 00", {dif.div_by_zero, dif.overflow}); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (dif.done === 1'b1 || dif.busy === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", seen); end
        launch(32'h0007_0000, 32'h0002_0000);
        wait_done(1, lat);
        n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL midrst_next_latency: got %0d expected 34", lat); end
        n_cmp++; if (dif.result !== 32'h0003_0000) begin n_err++; $display("FAIL midrst_next_result: got %h expected 00030000", dif.result); end
    endtask

    task automatic test_back_to_back();
        int lat;
        launch(32'hFFF9_0000, 32'h0002_0000);
        wait_done(1, lat);
        n_cmp++; if (dif.result !== 32'hFFFD_0000) begin n_err++; $display("FAIL b2b_first_result: got %h expected fffd0000", dif.result); end
        // start raised during the done cycle must be ignored
        dif.start = 1'b1; dif.operand1 = 32'h0007_0000; dif.operand2 = 32'h0002_0000;
        @(posedge clk); #1;
        n_cmp++; if (dif.busy !== 1'b0) begin n_err++; $display("FAIL b2b_start_in_done: got busy %b expected 0", dif.busy); end
        dif.operand1 = cpack(16'h000A, 16'h0014);
        dif.operand2 = cpack(16'h0001, 16'h0002);
        @(posedge clk); #1;
        dif.start = 1'b0; dif.operand1 = $urandom; dif.operand2 = $urandom;
        n_cmp++; if (dif.busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got busy %b expected 1", dif.busy); end
        wait_done(1, lat);
        n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL b2b_latency: got %0d expected 34", lat); end
        n_cmp++; if (dif.result !== 32'h000A_0000) begin n_err++; $display("FAIL b2b_result: got %h expected 000a0000", dif.result); end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        dif.start    = 1'b0;
        dif.operand1 = '0;
        dif.operand2 = '0;
        test_reset();
        test_plain();
        test_vectors();
        test_div_by_zero();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
